// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan controller.
package seg_pkg;
    localparam int NUM_DIGITS = 8;
    localparam logic [7:0] AN_IDLE = 8'hFF;
    localparam logic [7:0] CX_BLANK = 8'hFF;
    // Active-low g..a patterns, indexed by nibble (entry 0 is the rightmost element)
    localparam logic [15:0][6:0] HEX7_LUT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/hex7_decode.sv
// hex7_decode: nibble to active-low g..a segment pattern.
module hex7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = HEX7_LUT[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed seven-segment scanner with dead time,
// PWM brightness and frame-synchronous double-buffered updates.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SLOT_CYC = 100000,
    parameter int DEAD_CYC = 1000
) (
    input  logic                  sysCLK,
    input  logic                  reset,
    input  logic                  load,
    input  logic [31:0]           digits,
    input  logic [NUM_DIGITS-1:0] dp,
    input  logic [NUM_DIGITS-1:0] en,
    input  logic [2:0]            bright,
    output logic [7:0]            AN,
    output logic [7:0]            Cx,
    output logic                  frame_tick,
    output logic                  update_ack,
    output logic                  pending
);
    localparam int STEP = (SLOT_CYC - DEAD_CYC) / 8;
    localparam int CW = $clog2(SLOT_CYC + 1);

    logic [CW-1:0] slot_cnt, win_end, win_next;
    logic [2:0] slot_idx, next_bright;
    logic [31:0] pend_digits, act_digits;
    logic [NUM_DIGITS-1:0] pend_dp, act_dp, pend_en, act_en;
    logic [2:0] pend_bright, act_bright;
    logic slot_end, boundary, apply, on;
    logic [3:0] nib;
    logic [6:0] seg;

    hex7_decode u_dec (.nib(nib), .seg(seg));

    // The window end is latched at each slot wrap, using the bright value
    // that will be active in the coming slot (the pending one at a swap).
    always_comb begin
        slot_end = slot_cnt == CW'(SLOT_CYC - 1);
        boundary = slot_end && slot_idx == 3'd7;
        apply = boundary && pending;
        next_bright = apply ? pend_bright : act_bright;
        win_next = CW'(DEAD_CYC) + CW'(STEP) * CW'({1'b0, next_bright} + 4'd1);
        nib = act_digits[{slot_idx, 2'b00} +: 4];
        on = act_en[slot_idx] && slot_cnt >= CW'(DEAD_CYC) && slot_cnt < win_end;
    end

    always_ff @(posedge sysCLK or negedge reset) begin
        if (!reset) begin
            slot_cnt <= '0;
            slot_idx <= '0;
            win_end <= CW'(DEAD_CYC + STEP);
            pend_digits <= '0;
            pend_dp <= '0;
            pend_en <= '0;
            pend_bright <= '0;
            act_digits <= '0;
            act_dp <= '0;
            act_en <= '0;
            act_bright <= '0;
            pending <= 1'b0;
            update_ack <= 1'b0;
            frame_tick <= 1'b0;
            AN <= AN_IDLE;
            Cx <= CX_BLANK;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + CW'(1);
            if (slot_end) begin
                slot_idx <= slot_idx + 3'd1;
                win_end <= win_next;
            end
            if (load) begin
                pend_digits <= digits;
                pend_dp <= dp;
                pend_en <= en;
                pend_bright <= bright;
            end
            // A load coinciding with the boundary stays pending for the next frame
            if (apply) begin
                act_digits <= pend_digits;
                act_dp <= pend_dp;
                act_en <= pend_en;
                act_bright <= pend_bright;
            end
            pending <= load || (pending && !boundary);
            update_ack <= apply;
            frame_tick <= boundary;
            AN <= on ? ~(8'b1 << slot_idx) : AN_IDLE;
            Cx <= on ? {~act_dp[slot_idx], seg} : CX_BLANK;
        end
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for the 8-digit common-anode seven-segment display. It shares the single Cx segment bus among eight digit slots by sequencing AN, decoding a per-slot hex nibble, adding anti-ghosting dead time and PWM brightness. New display contents are double-buffered and applied only at frame boundaries, so no tearing occurs. It sits between user logic (counters, status) and the board pins.

Parameters:
SLOT_CYC, 100000, sysCLK cycles per digit slot (1 ms at 100 MHz; frame = 8 slots = 125 Hz)
DEAD_CYC, 1000, cycles at the start of each slot with all anodes off (anti-ghosting); must satisfy DEAD_CYC < SLOT_CYC
STEP (localparam), (SLOT_CYC-DEAD_CYC)/8, brightness quantum

Ports:
sysCLK  in  1  system clock
reset  in  1  asynchronous, active-low reset
load  in  1  one-cycle strobe; captures the four inputs below into the pending buffer
digits  in  32  nibble k (bits 4k+3:4k) = hex value for digit k
dp  in  8  bit k=1 lights the decimal point of digit k
en  in  8  bit k=1 enables digit k; disabled digits keep their anode off for the whole slot
bright  in  3  on-window = (bright+1)*STEP cycles after the dead time; 7 = full
AN  out  8  anodes, active-low; bit k = digit k
Cx  out  8  segments, active-low; bit7 = DP, bits 6..0 = g..a
frame_tick  out  1  one-cycle pulse on the last cycle of slot 7
update_ack  out  1  one-cycle pulse on the cycle the pending buffer is applied
pending  out  1  high from load until the buffer is applied

Behaviour:
- Reset (reset=0, async): slot_cnt=0, slot_idx=0, all buffers cleared (en=0, so all digits are blank), AN=8'hFF, Cx=8'hFF, frame_tick=0, update_ack=0, pending=0. Scan starts at slot 0, cycle 0 after release.
- slot_cnt counts 0..SLOT_CYC-1 and then wraps. On wrap, slot_idx increments mod 8 (7 to 0).
- Frame boundary = the cycle where slot_cnt=SLOT_CYC-1 and slot_idx=7. frame_tick=1 on that cycle.
- Buffering: load=1 copies digits/dp/en/bright into the pending registers and sets pending=1. A later load before the boundary overwrites them; the last load wins.
- On a frame boundary with pending=1, the pending registers are copied to the active registers, pending clears, and update_ack=1 on the same cycle. The active values are in use from slot 0, cycle 0 of the next frame.
- If load and the frame boundary occur on the same cycle, the old pending contents (if any) are applied and the new load stays pending. pending remains 1 and is applied at the next boundary.
- Anode on-condition for slot k = en[k] && slot_cnt >= DEAD_CYC && slot_cnt < DEAD_CYC + (bright+1)*STEP. Compute the on-window end once per slot from the active bright value; no runtime multiplier is needed beyond a shift-add by constant STEP.
- When the on-condition holds, AN=~(8'b1<<k); otherwise AN=8'hFF.
- Cx = {~dp[k], hex7(nibble k)} while the anode is on, else 8'hFF.
- hex7 mapping, active-low g..a: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
- AN and Cx are registered: they reflect the counter state of the previous cycle (1-cycle latency). frame_tick and update_ack are registered pulses aligned to the boundary cycle as seen at the output (same 1-cycle latency).
- At most one anode is ever low, including across slot transitions, because the dead time guarantees a gap.

Decomposition:
- Package seg_pkg: the hex7 pattern constants, AN_IDLE=8'hFF, CX_BLANK=8'hFF, NUM_DIGITS=8.
- One natural sub-module: hex7_decode, a combinational nibble-to-7-bit active-low pattern. Everything else lives in seg_scan_ctrl.

Test Plan:
(Bench uses SLOT_CYC=34, DEAD_CYC=2, so STEP=4.)
1. Release reset, no load -> AN=FF, Cx=FF for the full 272-cycle frame; frame_tick pulses every 272 cycles.
2. load digits=32'h76543210, dp=0, en=FF, bright=7 mid-frame -> pending=1; update_ack at the boundary. Next frame: slot 0 AN=FE, Cx=C0 for cycles 2..33; slot 1 AN=FD, Cx=F9; ... slot 7 AN=7F, Cx=F8.
3. en=8'h0F, dp=8'h08 -> slots 4..7 AN=FF throughout; slot 3 Cx=30 (DP on).
4. bright=1 -> each slot's AN is active only for slot_cnt 2..9, and FF for cycles 0..1 and 10..33.
5. Two loads in one frame (values A then B) -> a single update_ack; the next frame shows B. A load on the exact boundary cycle leaves pending=1, and it is applied one frame later.
6. Assert reset mid-slot 5 with a digit lit -> AN=FF and Cx=FF immediately (async). After release, scan restarts at slot 0 with all digits blank until a new load.
